// File: rtl/ahb_slave_arbiter_if.sv
// Purpose: bus bundle between the master BFMs, the arbiter and the shared AHB slave.
// Latency: none, wiring only.
// Backpressure: carries S_HREADYOUT/HREADY; the arbiter owns all stall decisions.
interface ahb_slave_arbiter_if #(
  parameter int NMST   = 2,
  parameter int AWIDTH = 10
);
  // master request side
  logic [NMST-1:0]        HBUSREQ;
  logic [NMST-1:0]        HLOCK;
  logic [NMST-1:0]        HGRANT;
  logic [1:0]             HMASTER;
  logic [2*NMST-1:0]      M_HTRANS;
  logic [AWIDTH*NMST-1:0] M_HADDR;
  logic [NMST-1:0]        M_HWRITE;
  logic [3*NMST-1:0]      M_HSIZE;
  logic [3*NMST-1:0]      M_HBURST;
  logic [4*NMST-1:0]      M_HPROT;
  logic [32*NMST-1:0]     M_HWDATA;
  // shared slave side
  logic                   S_HSEL;
  logic [1:0]             S_HTRANS;
  logic [AWIDTH-1:0]      S_HADDR;
  logic                   S_HWRITE;
  logic [2:0]             S_HSIZE;
  logic [2:0]             S_HBURST;
  logic [3:0]             S_HPROT;
  logic                   S_HMASTLOCK;
  logic [31:0]            S_HWDATA;
  logic                   S_HREADYOUT;
  logic [31:0]            S_HRDATA;
  logic                   S_HRESP;
  // response broadcast to all masters
  logic                   HREADY;
  logic [31:0]            HRDATA;
  logic                   HRESP;

  // arbiter view: consumes master requests and slave responses
  modport slave (
    input  HBUSREQ, HLOCK, M_HTRANS, M_HADDR, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HWDATA,
    input  S_HREADYOUT, S_HRDATA, S_HRESP,
    output HGRANT, HMASTER,
    output S_HSEL, S_HTRANS, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HWDATA,
    output HREADY, HRDATA, HRESP
  );

  // environment view: masters and slave model drive the arbiter inputs
  modport master (
    output HBUSREQ, HLOCK, M_HTRANS, M_HADDR, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HWDATA,
    output S_HREADYOUT, S_HRDATA, S_HRESP,
    input  HGRANT, HMASTER,
    input  S_HSEL, S_HTRANS, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HWDATA,
    input  HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Purpose: round-robin AHB arbiter sharing one slave between NMST masters, with lock support.
// Latency: request->HGRANT 1 cycle; HGRANT->HMASTER and HMASTER->data owner on next HREADY=1 edge.
// Backpressure: HREADY=0 freezes grant, owners, pointer and lock state; slave response is broadcast.
module ahb_slave_arbiter #(
  parameter int NMST   = 2,
  parameter int AWIDTH = 10,
  parameter int DEFMST = 0
) (
  input logic HCLK,
  input logic HRESETN,
  ahb_slave_arbiter_if.slave bus
);

  localparam logic [1:0]      HTRANS_IDLE = 2'b00;
  localparam logic [1:0]      DEF_IDX     = 2'(DEFMST);
  localparam logic [NMST-1:0] DEF_GRANT   = NMST'(1) << DEFMST;

  logic [NMST-1:0] grant_q, grant_d;
  logic [1:0]      hmaster_q, hmaster_d;
  logic [1:0]      dmst_q, dmst_d;
  logic [1:0]      last_q, last_d;
  logic            lock_q, lock_d;
  logic            mastlock_q, mastlock_d;

  // per-master views padded to 4 entries so 2-bit indices never fall off the end
  logic [3:0]        busreq4, hlock4, hwrite4;
  logic [1:0]        htrans_a [4];
  logic [AWIDTH-1:0] haddr_a  [4];
  logic [2:0]        hsize_a  [4];
  logic [2:0]        hburst_a [4];
  logic [3:0]        hprot_a  [4];
  logic [31:0]       hwdata_a [4];

  logic       hready;
  logic [1:0] gidx;
  logic [1:0] win;
  logic [1:0] idx;
  logic [1:0] sel;
  logic       any_req;
  logic       arb_ok;

  assign hready = bus.S_HREADYOUT;

  // unpack the flat per-master buses; unused slots read as zero
  always_comb begin
    busreq4 = '0;
    hlock4  = '0;
    hwrite4 = '0;
    for (int i = 0; i < 4; i++) begin
      htrans_a[i] = '0;
      haddr_a[i]  = '0;
      hsize_a[i]  = '0;
      hburst_a[i] = '0;
      hprot_a[i]  = '0;
      hwdata_a[i] = '0;
    end
    busreq4[NMST-1:0] = bus.HBUSREQ;
    hlock4[NMST-1:0]  = bus.HLOCK;
    hwrite4[NMST-1:0] = bus.M_HWRITE;
    for (int i = 0; i < NMST; i++) begin
      htrans_a[i] = bus.M_HTRANS[2*i +: 2];
      haddr_a[i]  = bus.M_HADDR[AWIDTH*i +: AWIDTH];
      hsize_a[i]  = bus.M_HSIZE[3*i +: 3];
      hburst_a[i] = bus.M_HBURST[3*i +: 3];
      hprot_a[i]  = bus.M_HPROT[4*i +: 4];
      hwdata_a[i] = bus.M_HWDATA[32*i +: 32];
    end
  end

  // current grantee index and round-robin winner search starting after last
  always_comb begin
    gidx    = 2'd0;
    win     = DEF_IDX;
    idx     = 2'd0;
    any_req = 1'b0;
    for (int i = 0; i < NMST; i++) begin
      if (grant_q[i]) gidx = 2'(i);
    end
    for (int k = 0; k < NMST; k++) begin
      idx = 2'((int'(last_q) + 1 + k) % NMST);
      if (!any_req && busreq4[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // next-state: arbitration only when the grantee is not mid-burst and no lock is held
  always_comb begin
    grant_d    = grant_q;
    hmaster_d  = hmaster_q;
    dmst_d     = dmst_q;
    last_d     = last_q;
    lock_d     = lock_q;
    mastlock_d = mastlock_q;
    sel        = any_req ? win : DEF_IDX;
    arb_ok     = hready && !(lock_q && hlock4[gidx]) &&
                 (!busreq4[gidx] || htrans_a[gidx] == HTRANS_IDLE);
    if (hready) begin
      hmaster_d  = gidx;
      mastlock_d = hlock4[gidx];
      dmst_d     = hmaster_q;
      // owner released its lock: flag clears even if the grantee keeps the bus
      if (lock_q && !hlock4[gidx]) lock_d = 1'b0;
      if (arb_ok) begin
        for (int i = 0; i < NMST; i++) grant_d[i] = (sel == 2'(i));
        if (any_req) begin
          last_d = win;
          lock_d = hlock4[win];
        end else begin
          lock_d = 1'b0;
        end
      end
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      grant_q    <= DEF_GRANT;
      hmaster_q  <= DEF_IDX;
      dmst_q     <= DEF_IDX;
      last_q     <= DEF_IDX;
      lock_q     <= 1'b0;
      mastlock_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      hmaster_q  <= hmaster_d;
      dmst_q     <= dmst_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign bus.HGRANT      = grant_q;
  assign bus.HMASTER     = hmaster_q;
  assign bus.S_HSEL      = 1'b1;
  // no new transfer may reach the slave while reset is asserted
  assign bus.S_HTRANS    = HRESETN ? htrans_a[hmaster_q] : HTRANS_IDLE;
  assign bus.S_HADDR     = haddr_a[hmaster_q];
  assign bus.S_HWRITE    = hwrite4[hmaster_q];
  assign bus.S_HSIZE     = hsize_a[hmaster_q];
  assign bus.S_HBURST    = hburst_a[hmaster_q];
  assign bus.S_HPROT     = hprot_a[hmaster_q];
  assign bus.S_HMASTLOCK = mastlock_q;
  assign bus.S_HWDATA    = hwdata_a[dmst_q];
  assign bus.HREADY      = bus.S_HREADYOUT;
  assign bus.HRDATA      = bus.S_HRDATA;
  assign bus.HRESP       = bus.S_HRESP;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Purpose: directed self-checking bench for ahb_slave_arbiter with two masters.
// Latency: checks sampled 1ns after each rising edge or after input changes.
// Backpressure: slave wait states driven directly on S_HREADYOUT.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [31:0] WD0   = 32'h0D0D_0D0D;
  localparam logic [31:0] WD1   = 32'h1111_1111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ahb_slave_arbiter_if #(.NMST(2), .AWIDTH(10)) bus ();

  ahb_slave_arbiter #(.NMST(2), .AWIDTH(10), .DEFMST(0)) dut (
    .HCLK    (clk),
    .HRESETN (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [9:0] addr,
                     input logic wr, input logic [2:0] burst);
    bus.M_HTRANS[2*m +: 2]  = tr;
    bus.M_HADDR[10*m +: 10] = addr;
    bus.M_HWRITE[m]         = wr;
    bus.M_HBURST[3*m +: 3]  = burst;
  endtask

  task automatic clear_inputs();
    bus.HBUSREQ     = '0;
    bus.HLOCK       = '0;
    bus.M_HTRANS    = '0;
    bus.M_HADDR     = '0;
    bus.M_HWRITE    = '0;
    bus.M_HSIZE     = {3'b010, 3'b010};
    bus.M_HBURST    = '0;
    bus.M_HPROT     = {4'b0011, 4'b0001};
    bus.M_HWDATA    = {WD1, WD0};
    bus.S_HREADYOUT = 1'b1;
    bus.S_HRDATA    = '0;
    bus.S_HRESP     = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // reset: master 0 drives NONSEQ but the slave must see IDLE
    rst_n = 1'b0;
    clear_inputs();
    drv(0, NONSEQ, 10'h3F0, 1'b0, SINGLE);
    repeat (3) tick();
    check_val("rst_hgrant", 32'(bus.HGRANT), 32'h1);
    check_val("rst_hmaster", 32'(bus.HMASTER), 32'h0);
    check_val("rst_htrans", 32'(bus.S_HTRANS), 32'(IDLE));
    check_val("rst_hsel", 32'(bus.S_HSEL), 32'h1);
    rst_n = 1'b1;
    drv(0, IDLE, 10'h000, 1'b0, SINGLE);
    tick();
    check_val("park_hgrant", 32'(bus.HGRANT), 32'h1);
    check_val("park_hmaster", 32'(bus.HMASTER), 32'h0);

    // master 1 alone: single write of 0xA5A5_0001 to 0x010
    reset_dut();
    bus.HBUSREQ = 2'b10;
    tick();
    check_val("m1_grant", 32'(bus.HGRANT), 32'h2);
    check_val("m1_hmaster_e1", 32'(bus.HMASTER), 32'h0);
    drv(1, NONSEQ, 10'h010, 1'b1, SINGLE);
    tick();
    check_val("m1_hmaster", 32'(bus.HMASTER), 32'h1);
    check_val("m1_haddr", 32'(bus.S_HADDR), 32'h010);
    check_val("m1_htrans", 32'(bus.S_HTRANS), 32'(NONSEQ));
    check_val("m1_hwrite", 32'(bus.S_HWRITE), 32'h1);
    check_val("m1_hprot", 32'(bus.S_HPROT), 32'h3);
    bus.M_HWDATA[63:32] = 32'hA5A5_0001;
    drv(1, IDLE, 10'h010, 1'b1, SINGLE);
    bus.HBUSREQ = 2'b00;
    tick();
    check_val("m1_hwdata", bus.S_HWDATA, 32'hA5A5_0001);
    check_val("m1_park", 32'(bus.HGRANT), 32'h1);
    bus.M_HWDATA[63:32] = WD1;

    // both request continuously with single transfers: strict alternation
    reset_dut();
    bus.M_HADDR = {10'h200, 10'h100};
    bus.HBUSREQ = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      int m;
      tick();
      m = (k % 2 == 1) ? 0 : 1;
      check_val($sformatf("rr_grant_%0d", k), 32'(bus.HGRANT), (k % 2 == 1) ? 32'h2 : 32'h1);
      check_val($sformatf("rr_hmaster_%0d", k), 32'(bus.HMASTER), 32'(m));
      check_val($sformatf("rr_haddr_%0d", k), 32'(bus.S_HADDR), (m == 0) ? 32'h100 : 32'h200);
      drv(m, NONSEQ, (m == 0) ? 10'h100 : 10'h200, 1'b0, SINGLE);
      drv(1 - m, IDLE, (m == 0) ? 10'h200 : 10'h100, 1'b0, SINGLE);
    end

    // master 0 INCR4 read from 0x020 is not split by master 1's request
    reset_dut();
    bus.HBUSREQ = 2'b01;
    tick();
    check_val("b4_grant0", 32'(bus.HGRANT), 32'h1);
    bus.HBUSREQ = 2'b11;
    for (int b = 0; b < 4; b++) begin
      drv(0, (b == 0) ? NONSEQ : SEQ, 10'(32'h020 + 4 * b), 1'b0, INCR4);
      #1;
      check_val($sformatf("b4_haddr_%0d", b), 32'(bus.S_HADDR), 32'h020 + 32'(4 * b));
      check_val($sformatf("b4_htrans_%0d", b), 32'(bus.S_HTRANS), (b == 0) ? 32'(NONSEQ) : 32'(SEQ));
      check_val($sformatf("b4_hburst_%0d", b), 32'(bus.S_HBURST), 32'(INCR4));
      tick();
      check_val($sformatf("b4_grant_%0d", b), 32'(bus.HGRANT), 32'h1);
    end
    drv(0, IDLE, 10'h000, 1'b0, SINGLE);
    bus.HBUSREQ = 2'b10;
    tick();
    check_val("b4_grant1", 32'(bus.HGRANT), 32'h2);
    check_val("b4_hwdata_last", bus.S_HWDATA, WD0);
    tick();
    check_val("b4_hmaster1", 32'(bus.HMASTER), 32'h1);
    check_val("b4_hwdata_hold", bus.S_HWDATA, WD0);
    tick();
    check_val("b4_hwdata_m1", bus.S_HWDATA, WD1);

    // two wait states on the handover cycle freeze every register
    reset_dut();
    bus.HBUSREQ = 2'b10;
    tick();
    check_val("ws_grant_e1", 32'(bus.HGRANT), 32'h2);
    tick();
    check_val("ws_hmaster_e2", 32'(bus.HMASTER), 32'h1);
    check_val("ws_hwdata_e2", bus.S_HWDATA, WD0);
    bus.S_HREADYOUT = 1'b0;
    bus.S_HRDATA    = 32'hDEAD_BEEF;
    bus.S_HRESP     = 1'b1;
    bus.HBUSREQ     = 2'b11;
    #1;
    check_val("ws_hready", 32'(bus.HREADY), 32'h0);
    check_val("ws_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
    check_val("ws_hresp", 32'(bus.HRESP), 32'h1);
    for (int w = 0; w < 2; w++) begin
      tick();
      check_val($sformatf("ws_grant_%0d", w), 32'(bus.HGRANT), 32'h2);
      check_val($sformatf("ws_hmaster_%0d", w), 32'(bus.HMASTER), 32'h1);
      check_val($sformatf("ws_hwdata_%0d", w), bus.S_HWDATA, WD0);
    end
    bus.S_HREADYOUT = 1'b1;
    bus.S_HRESP     = 1'b0;
    bus.HBUSREQ     = 2'b10;
    #1;
    check_val("ws_hready_up", 32'(bus.HREADY), 32'h1);
    tick();
    check_val("ws_hwdata_new", bus.S_HWDATA, WD1);
    check_val("ws_grant_end", 32'(bus.HGRANT), 32'h2);

    // locked read-modify-write by master 0 to 0x030 holds off master 1
    reset_dut();
    bus.HBUSREQ = 2'b01;
    bus.HLOCK   = 2'b01;
    tick();
    check_val("lk_grant_e1", 32'(bus.HGRANT), 32'h1);
    check_val("lk_mlock_e1", 32'(bus.S_HMASTLOCK), 32'h1);
    drv(0, NONSEQ, 10'h030, 1'b0, SINGLE);
    bus.HBUSREQ = 2'b11;
    #1;
    check_val("lk_haddr_rd", 32'(bus.S_HADDR), 32'h030);
    tick();
    check_val("lk_grant_e2", 32'(bus.HGRANT), 32'h1);
    check_val("lk_mlock_e2", 32'(bus.S_HMASTLOCK), 32'h1);
    drv(0, IDLE, 10'h030, 1'b0, SINGLE);
    tick();
    check_val("lk_grant_e3", 32'(bus.HGRANT), 32'h1);
    drv(0, NONSEQ, 10'h030, 1'b1, SINGLE);
    #1;
    check_val("lk_hwrite", 32'(bus.S_HWRITE), 32'h1);
    tick();
    check_val("lk_grant_e4", 32'(bus.HGRANT), 32'h1);
    check_val("lk_mlock_e4", 32'(bus.S_HMASTLOCK), 32'h1);
    drv(0, IDLE, 10'h000, 1'b0, SINGLE);
    bus.HLOCK   = 2'b00;
    bus.HBUSREQ = 2'b10;
    tick();
    check_val("lk_grant_e5", 32'(bus.HGRANT), 32'h2);
    check_val("lk_mlock_e5", 32'(bus.S_HMASTLOCK), 32'h0);
    tick();
    check_val("lk_hmaster_e6", 32'(bus.HMASTER), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Round-robin AHB arbiter that shares one AHB slave (the UART-side AHB slave BFM / memory model) between up to 4 bus masters using HBUSREQ/HGRANT/HLOCK handshakes.
- Multiplexes address/control from the address-phase owner and write data from the data-phase owner onto the slave.
- Broadcasts the slave's HREADY, HRDATA and HRESP back to all masters.
- Sits between the testbench master BFMs and the slave in the simulation/verification environment.

Parameters:
- NMST, 2, number of masters (2..4).
- AWIDTH, 10, address width, matching the slave HADDR.
- DEFMST, 0, default (parking) master index.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- HBUSREQ  in  NMST  per-master bus request.
- HLOCK  in  NMST  per-master locked-access request.
- HGRANT  out  NMST  one-hot grant.
- HMASTER  out  2  index of the address-phase owner.
- M_HTRANS  in  2*NMST  packed per-master HTRANS; master i at [2i+1:2i].
- M_HADDR  in  AWIDTH*NMST  packed per-master HADDR.
- M_HWRITE  in  NMST  per-master HWRITE.
- M_HSIZE  in  3*NMST  per-master HSIZE.
- M_HBURST  in  3*NMST  per-master HBURST.
- M_HPROT  in  4*NMST  per-master HPROT.
- M_HWDATA  in  32*NMST  per-master HWDATA.
- S_HSEL  out  1  slave select, constant 1.
- S_HTRANS, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT  out  2/AWIDTH/1/3/3/4  muxed address phase.
- S_HMASTLOCK  out  1  lock flag of the address-phase owner.
- S_HWDATA  out  32  write data muxed by the data-phase owner.
- S_HREADYOUT  in  1  slave ready.
- S_HRDATA  in  32  slave read data.
- S_HRESP  in  1  slave response.
- HREADY  out  1  equals S_HREADYOUT; drives slave HREADYIN and all masters.
- HRDATA  out  32  equals S_HRDATA.
- HRESP  out  1  equals S_HRESP.

Behaviour:
- Reset (HRESETN=0 at a rising edge) loads the following registers:
  - HGRANT = one-hot(DEFMST).
  - HMASTER = DEFMST.
  - Data-phase owner dmst = DEFMST.
  - Round-robin pointer last = DEFMST.
  - lock flags = 0.
- While HRESETN=0, S_HTRANS is forced to IDLE (00).
- Reset mid-transfer abandons the transfer; no completion is owed.
- Registers are three-stage:
  - HGRANT is updated by arbitration.
  - HMASTER <= index(HGRANT) on an edge with HREADY=1.
  - dmst <= HMASTER on an edge with HREADY=1.
  - When HREADY=0, HGRANT, HMASTER, dmst, last and the lock flags all hold.
- Address-phase mux: S_HTRANS/HADDR/HWRITE/HSIZE/HBURST/HPROT = fields of master HMASTER.
- Data-phase mux: S_HWDATA = M_HWDATA of master dmst.
- Arbitration is permitted on an edge only when all of the following hold:
  - HREADY=1.
  - locked-owner flag is clear.
  - the current grantee g either has HBUSREQ[g]=0 or drives M_HTRANS[g]=IDLE.
- Masters keep HBUSREQ high through a burst; arbitration never splits a burst whose owner holds request and drives NONSEQ/SEQ/BUSY.
- Arbitration winner:
  - The first requesting master scanning from last+1 upward, modulo NMST, starting index included.
  - last <= winner.
  - If no master requests, grant parks on DEFMST and last is unchanged.
  - A sole requester keeps the grant, with no IDLE-cycle penalty.
- Lock:
  - At a grant edge, the locked-owner flag <= HLOCK[winner].
  - While the flag is set, arbitration is blocked until an HREADY=1 edge where HLOCK[owner]=0.
  - That edge clears the flag and performs normal arbitration on the same edge.
  - S_HMASTLOCK = HLOCK of HMASTER, registered alongside HMASTER.
- Latency:
  - Request to HGRANT: 1 cycle when arbitration is permitted.
  - HGRANT to HMASTER: the next HREADY=1 edge.
  - Address to data ownership: the next HREADY=1 edge.
- ERROR response: passed through unchanged. The arbiter does not force IDLE; the master is responsible.
- Simultaneous requests with last=1: master 0 wins before master 1.
- Out-of-range indices when NMST<4 are never granted.

Test Plan:
- Reset: hold HRESETN=0 for 3 cycles → HGRANT=01, HMASTER=0, S_HTRANS=00; release → parked on master 0.
- Master 1 alone requests and does a single NONSEQ write of 0xA5A5_0001 to 0x010 → HGRANT=10 after 1 cycle; S_HADDR=0x010 while HMASTER=1; S_HWDATA=0xA5A5_0001 in the following cycle.
- Both masters request continuously, each doing single transfers → grants alternate 0,1,0,1; no master is granted twice in a row.
- Master 0 runs an INCR4 read from 0x020 while master 1 requests → 4 beats complete uninterrupted; HGRANT moves to master 1 only after master 0 drops HBUSREQ; S_HWDATA stays with master 0 through the last data phase.
- Slave inserts 2 wait states (S_HREADYOUT=0) on the handover cycle → HGRANT, HMASTER and dmst hold; S_HWDATA stays on the old owner until HREADY=1.
- Master 0 issues a locked read-modify-write (HLOCK=1) to 0x030 while master 1 requests → S_HMASTLOCK=1 for both transfers; no grant change until HLOCK[0]=0; then grant goes to master 1.
